i2c_cmd_master: RTL and testbench

Command sequencer that sits directly upstream of the Wishbone slave port of the I2C master core. It accepts single-byte I2C read/write commands on a valid/ready interface and turns each one into the required sequence of Wishbone register accesses: TXR, CR, SR polling and RXR. It returns the read data and a completion status on a valid/ready response interface. After reset it programs the core's prescaler and enable bit once, then serves commands one at a time.

---
 rtl/i2c_cmd_pkg.sv | 67 ++++++
 rtl/wb_single_access.sv | 71 +++++++
 rtl/i2c_cmd_master.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_i2c_cmd_master.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_cmd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_cmd_pkg
//  Description : Shared definitions for the I2C command sequencer. Holds the
//                I2C core register map, control-register command bytes, the
//                status-register bit positions, and the sequencer state and
//                error encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package i2c_cmd_pkg;

   // I2C core register addresses
   localparam logic [2:0] c_adr_prerlo = 3'd0;
   localparam logic [2:0] c_adr_prerhi = 3'd1;
   localparam logic [2:0] c_adr_ctr    = 3'd2;
   localparam logic [2:0] c_adr_txr    = 3'd3;   // write side
   localparam logic [2:0] c_adr_rxr    = 3'd3;   // read side
   localparam logic [2:0] c_adr_cr     = 3'd4;   // write side
   localparam logic [2:0] c_adr_sr     = 3'd4;   // read side

   // Core enable bit in CTR
   localparam logic [7:0] c_ctr_en = 8'h80;

   // Command register values
   localparam logic [7:0] c_cr_sta_wr     = 8'h90;
   localparam logic [7:0] c_cr_sto_wr     = 8'h50;
   localparam logic [7:0] c_cr_sto_rd_ack = 8'h68;  // master NACKs the only byte
   localparam logic [7:0] c_cr_sto        = 8'h40;

   // Status register bit positions
   localparam int c_sr_rxack = 7;
   localparam int c_sr_busy  = 6;
   localparam int c_sr_al    = 5;
   localparam int c_sr_tip   = 1;

   typedef enum logic [3:0] {
      ST_INIT_PL   = 4'd0,
      ST_INIT_PH   = 4'd1,
      ST_INIT_CTR  = 4'd2,
      ST_IDLE      = 4'd3,
      ST_ADDR_TX   = 4'd4,
      ST_ADDR_CR   = 4'd5,
      ST_ADDR_POLL = 4'd6,
      ST_DATA_TX   = 4'd7,
      ST_DATA_CR   = 4'd8,
      ST_DATA_POLL = 4'd9,
      ST_RD_RXR    = 4'd10,
      ST_STOP_CR   = 4'd11,
      ST_STOP_POLL = 4'd12,
      ST_RESP      = 4'd13
   } state_t;

   typedef enum logic [2:0] {
      ERR_OK        = 3'd0,
      ERR_ADDR_NACK = 3'd1,
      ERR_DATA_NACK = 3'd2,
      ERR_ARB_LOST  = 3'd3,
      ERR_TIMEOUT   = 3'd4
   } err_t;

   // States that repeatedly read SR and share the poll counter
   function automatic logic is_poll_state(input state_t s);
      return (s == ST_ADDR_POLL) || (s == ST_DATA_POLL) || (s == ST_STOP_POLL);
   endfunction

endpackage
`default_nettype wire

// File: rtl/wb_single_access.sv
`default_nettype none
// ============================================================================
//  Module      : wb_single_access
//  Description : Performs one Wishbone classic read or write per request.
//                Bus outputs are registered; cyc/stb drop the cycle after the
//                acknowledge. done pulses in the acknowledge cycle, and rdat
//                is valid together with done.
//  Ports       : wb_clk_i/arst_i   clock, async active-low reset
//                req/we/adr/wdat   access request (taken only while idle)
//                done/rdat         completion pulse and read data
//                wb_*              Wishbone master signals
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_single_access (
   input  logic       wb_clk_i,
   input  logic       arst_i,
   input  logic       req,
   input  logic       we,
   input  logic [2:0] adr,
   input  logic [7:0] wdat,
   output logic       done,
   output logic [7:0] rdat,
   output logic [2:0] wb_adr_o,
   output logic [7:0] wb_dat_o,
   input  logic [7:0] wb_dat_i,
   output logic       wb_we_o,
   output logic       wb_stb_o,
   output logic       wb_cyc_o,
   input  logic       wb_ack_i
);

   logic       r_cyc;
   logic       r_stb;
   logic       r_we;
   logic [2:0] r_adr;
   logic [7:0] r_dat;
   logic       w_done;

   // An acknowledge outside an active strobe is not ours
   assign w_done = r_stb & wb_ack_i;

   always_ff @(posedge wb_clk_i or negedge arst_i) begin
      if (!arst_i) begin
         r_cyc <= 1'b0;
         r_stb <= 1'b0;
         r_we  <= 1'b0;
         r_adr <= 3'd0;
         r_dat <= 8'h00;
      end else if (w_done) begin
         r_cyc <= 1'b0;
         r_stb <= 1'b0;
         r_we  <= 1'b0;
      end else if (req && !r_stb) begin
         r_cyc <= 1'b1;
         r_stb <= 1'b1;
         r_we  <= we;
         r_adr <= adr;
         r_dat <= wdat;
      end
   end

   assign done     = w_done;
   assign rdat     = wb_dat_i;
   assign wb_cyc_o = r_cyc;
   assign wb_stb_o = r_stb;
   assign wb_we_o  = r_we;
   assign wb_adr_o = r_adr;
   assign wb_dat_o = r_dat;

endmodule
`default_nettype wire

// File: rtl/i2c_cmd_master.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_cmd_master
//  Description : Turns single-byte I2C read/write commands into the Wishbone
//                register access sequence of the I2C master core (TXR, CR,
//                SR polling, RXR) and returns data plus a status code. The
//                prescaler and core enable are programmed once after reset.
//  Ports       : wb_clk_i, arst_i            clock, async active-low reset
//                cmd_valid/ready/rw/addr/data command channel
//                rsp_valid/ready/data/err    response channel
//                busy                        high outside IDLE
//                wb_*                        Wishbone master to the I2C core
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_cmd_master
   import i2c_cmd_pkg::*;
#(
   parameter logic [15:0] PRESCALE = 16'h0063,
   parameter int          POLL_MAX = 1024
) (
   input  logic       wb_clk_i,
   input  logic       arst_i,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_rw,
   input  logic [6:0] cmd_addr,
   input  logic [7:0] cmd_data,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_data,
   output logic [2:0] rsp_err,
   output logic       busy,
   output logic [2:0] wb_adr_o,
   output logic [7:0] wb_dat_o,
   input  logic [7:0] wb_dat_i,
   output logic       wb_we_o,
   output logic       wb_stb_o,
   output logic       wb_cyc_o,
   input  logic       wb_ack_i
);

   localparam int c_cnt_w = $clog2(POLL_MAX + 1);
   localparam logic [c_cnt_w-1:0] c_poll_last = c_cnt_w'(POLL_MAX - 1);

   state_t             r_state;
   state_t             w_state_nxt;

   logic               r_rw;
   logic [6:0]         r_addr;
   logic [7:0]         r_data;
   err_t               r_err;
   logic [7:0]         r_rsp_data;
   logic [c_cnt_w-1:0] r_poll_cnt;

   logic               w_req;
   logic               w_we;
   logic [2:0]         w_adr;
   logic [7:0]         w_wdat;
   logic               w_done;
   logic [7:0]         w_rdat;
   logic               w_accept;
   logic               w_err_set;
   err_t               w_err_val;
   logic               w_poll_last;
   logic               w_wb_active;

   wb_single_access u_wb (
      .wb_clk_i (wb_clk_i),
      .arst_i   (arst_i),
      .req      (w_req),
      .we       (w_we),
      .adr      (w_adr),
      .wdat     (w_wdat),
      .done     (w_done),
      .rdat     (w_rdat),
      .wb_adr_o (wb_adr_o),
      .wb_dat_o (wb_dat_o),
      .wb_dat_i (wb_dat_i),
      .wb_we_o  (wb_we_o),
      .wb_stb_o (wb_stb_o),
      .wb_cyc_o (wb_cyc_o),
      .wb_ack_i (wb_ack_i)
   );

   // An access is in flight whenever strobe is up; a new request is only
   // raised once it has dropped, which yields the idle cycle between accesses.
   assign w_wb_active = wb_stb_o;
   assign w_poll_last = (r_poll_cnt == c_poll_last);

   always_ff @(posedge wb_clk_i or negedge arst_i) begin
      if (!arst_i) begin
         r_state <= ST_INIT_PL;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_req       = 1'b0;
      w_we        = 1'b0;
      w_adr       = c_adr_sr;
      w_wdat      = 8'h00;
      w_accept    = 1'b0;
      w_err_set   = 1'b0;
      w_err_val   = ERR_OK;

      case (r_state)
         ST_INIT_PL: begin
            w_req  = !w_wb_active;
            w_we   = 1'b1;
            w_adr  = c_adr_prerlo;
            w_wdat = PRESCALE[7:0];
            if (w_done) w_state_nxt = ST_INIT_PH;
         end
         ST_INIT_PH: begin
            w_req  = !w_wb_active;
            w_we   = 1'b1;
            w_adr  = c_adr_prerhi;
            w_wdat = PRESCALE[15:8];
            if (w_done) w_state_nxt = ST_INIT_CTR;
         end
         ST_INIT_CTR: begin
            w_req  = !w_wb_active;
            w_we   = 1'b1;
            w_adr  = c_adr_ctr;
            w_wdat = c_ctr_en;
            if (w_done) w_state_nxt = ST_IDLE;
         end
         ST_IDLE: begin
            // The address byte is launched straight from the handshake so its
            // strobe appears in the cycle right after acceptance.
            w_we   = 1'b1;
            w_adr  = c_adr_txr;
            w_wdat = {cmd_addr, cmd_rw};
            if (cmd_valid) begin
               w_accept    = 1'b1;
               w_req       = 1'b1;
               w_state_nxt = ST_ADDR_TX;
            end
         end
         ST_ADDR_TX: begin
            w_req  = !w_wb_active;
            w_we   = 1'b1;
            w_adr  = c_adr_txr;
            w_wdat = {r_addr, r_rw};
            if (w_done) w_state_nxt = ST_ADDR_CR;
         end
         ST_ADDR_CR: begin
            w_req  = !w_wb_active;
            w_we   = 1'b1;
            w_adr  = c_adr_cr;
            w_wdat = c_cr_sta_wr;
            if (w_done) w_state_nxt = ST_ADDR_POLL;
         end
         ST_ADDR_POLL: begin
            w_req = !w_wb_active;
            w_adr = c_adr_sr;
            if (w_done) begin
               if (w_rdat[c_sr_tip]) begin
                  if (w_poll_last) begin
                     w_err_set   = 1'b1;
                     w_err_val   = ERR_TIMEOUT;
                     w_state_nxt = ST_RESP;
                  end
               end else if (w_rdat[c_sr_al]) begin
                  w_err_set   = 1'b1;
                  w_err_val   = ERR_ARB_LOST;
                  w_state_nxt = ST_RESP;
               end else if (w_rdat[c_sr_rxack]) begin
                  w_err_set   = 1'b1;
                  w_err_val   = ERR_ADDR_NACK;
                  w_state_nxt = ST_STOP_CR;
               end else begin
                  w_state_nxt = r_rw ? ST_DATA_CR : ST_DATA_TX;
               end
            end
         end
         ST_DATA_TX: begin
            w_req  = !w_wb_active;
            w_we   = 1'b1;
            w_adr  = c_adr_txr;
            w_wdat = r_data;
            if (w_done) w_state_nxt = ST_DATA_CR;
         end
         ST_DATA_CR: begin
            w_req  = !w_wb_active;
            w_we   = 1'b1;
            w_adr  = c_adr_cr;
            w_wdat = r_rw ? c_cr_sto_rd_ack : c_cr_sto_wr;
            if (w_done) w_state_nxt = ST_DATA_POLL;
         end
         ST_DATA_POLL: begin
            // STOP was issued with the data byte, so every exit goes to the
            // response (via RXR for reads).
            w_req = !w_wb_active;
            w_adr = c_adr_sr;
            if (w_done) begin
               if (w_rdat[c_sr_tip]) begin
                  if (w_poll_last) begin
                     w_err_set   = 1'b1;
                     w_err_val   = ERR_TIMEOUT;
                     w_state_nxt = ST_RESP;
                  end
               end else if (w_rdat[c_sr_al]) begin
                  w_err_set   = 1'b1;
                  w_err_val   = ERR_ARB_LOST;
                  w_state_nxt = ST_RESP;
               end else if (r_rw) begin
                  w_state_nxt = ST_RD_RXR;
               end else begin
                  if (w_rdat[c_sr_rxack]) begin
                     w_err_set = 1'b1;
                     w_err_val = ERR_DATA_NACK;
                  end
                  w_state_nxt = ST_RESP;
               end
            end
         end
         ST_RD_RXR: begin
            w_req = !w_wb_active;
            w_adr = c_adr_rxr;
            if (w_done) w_state_nxt = ST_RESP;
         end
         ST_STOP_CR: begin
            w_req  = !w_wb_active;
            w_we   = 1'b1;
            w_adr  = c_adr_cr;
            w_wdat = c_cr_sto;
            if (w_done) w_state_nxt = ST_STOP_POLL;
         end
         ST_STOP_POLL: begin
            w_req = !w_wb_active;
            w_adr = c_adr_sr;
            if (w_done) begin
               if (w_rdat[c_sr_busy]) begin
                  if (w_poll_last) begin
                     w_err_set   = 1'b1;
                     w_err_val   = ERR_TIMEOUT;
                     w_state_nxt = ST_RESP;
                  end
               end else begin
                  w_state_nxt = ST_RESP;
               end
            end
         end
         ST_RESP: begin
            if (rsp_ready) w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_INIT_PL;
         end
      endcase
   end

   // Poll counter: held at zero outside the poll states, so it is clear on
   // entry to each of them; counts completed SR reads.
   always_ff @(posedge wb_clk_i or negedge arst_i) begin
      if (!arst_i) begin
         r_poll_cnt <= '0;
      end else if (!is_poll_state(r_state)) begin
         r_poll_cnt <= '0;
      end else if (w_done) begin
         r_poll_cnt <= r_poll_cnt + 1'b1;
      end
   end

   always_ff @(posedge wb_clk_i or negedge arst_i) begin
      if (!arst_i) begin
         r_rw       <= 1'b0;
         r_addr     <= 7'h00;
         r_data     <= 8'h00;
         r_err      <= ERR_OK;
         r_rsp_data <= 8'h00;
      end else begin
         if (w_accept) begin
            r_rw       <= cmd_rw;
            r_addr     <= cmd_addr;
            r_data     <= cmd_data;
            r_err      <= ERR_OK;
            r_rsp_data <= 8'h00;
         end
         if (w_err_set) begin
            r_err <= w_err_val;
         end
         if ((r_state == ST_RD_RXR) && w_done) begin
            r_rsp_data <= w_rdat;
         end
      end
   end

   assign cmd_ready = (r_state == ST_IDLE);
   assign busy      = (r_state != ST_IDLE);
   assign rsp_valid = (r_state == ST_RESP);
   assign rsp_data  = r_rsp_data;
   assign rsp_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_i2c_cmd_master.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_i2c_cmd_master
//  Description : Self-checking bench for i2c_cmd_master. A Wishbone slave
//                model emulates the I2C core, replaying a scripted sequence
//                of SR values; a command-level reference model derives the
//                expected register access list and response.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_cmd_master;

   localparam int          POLL_MAX = 8;
   localparam logic [15:0] PRESCALE = 16'h0063;

   typedef struct packed {
      logic       we;
      logic [2:0] adr;
      logic [7:0] dat;
   } acc_t;

   logic       wb_clk_i  = 1'b0;
   logic       arst_i    = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic       cmd_rw    = 1'b0;
   logic [6:0] cmd_addr  = 7'h00;
   logic [7:0] cmd_data  = 8'h00;
   logic       rsp_valid;
   logic       rsp_ready = 1'b0;
   logic [7:0] rsp_data;
   logic [2:0] rsp_err;
   logic       busy;
   logic [2:0] wb_adr_o;
   logic [7:0] wb_dat_o;
   logic [7:0] wb_dat_i  = 8'h00;
   logic       wb_we_o;
   logic       wb_stb_o;
   logic       wb_cyc_o;
   logic       wb_ack_i  = 1'b0;

   int         errors = 0;
   int         checks = 0;
   int         cyc_cnt = 0;
   int         last_ack_cyc = 0;

   acc_t       log_q[$];
   acc_t       exp_q[$];
   logic [7:0] sr_script[$];
   logic [7:0] sr_default = 8'h00;
   logic [7:0] rxr_val = 8'h00;
   int         slv_si = 0;
   int         slv_wait = -1;
   bit         slv_real = 1'b0;
   bit         spurious_en = 1'b0;
   logic [2:0] exp_err;
   logic [7:0] exp_data;

   i2c_cmd_master #(
      .PRESCALE (PRESCALE),
      .POLL_MAX (POLL_MAX)
   ) dut (
      .wb_clk_i  (wb_clk_i),
      .arst_i    (arst_i),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_rw    (cmd_rw),
      .cmd_addr  (cmd_addr),
      .cmd_data  (cmd_data),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .busy      (busy),
      .wb_adr_o  (wb_adr_o),
      .wb_dat_o  (wb_dat_o),
      .wb_dat_i  (wb_dat_i),
      .wb_we_o   (wb_we_o),
      .wb_stb_o  (wb_stb_o),
      .wb_cyc_o  (wb_cyc_o),
      .wb_ack_i  (wb_ack_i)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   always @(posedge wb_clk_i) cyc_cnt <= cyc_cnt + 1;

   // I2C core model: acks after 0..2 wait cycles, logs each access
   always @(negedge wb_clk_i) begin
      if (!arst_i) begin
         wb_ack_i = 1'b0;
         slv_wait = -1;
         slv_real = 1'b0;
      end else if (wb_ack_i) begin
         wb_ack_i = 1'b0;
         if (slv_real) begin
            checks++;
            if (wb_stb_o !== 1'b0) begin
               errors++;
               $display("FAIL wb_stb_drop: stb=%b the cycle after ack, required 0", wb_stb_o);
            end
         end
         slv_real = 1'b0;
      end else if (wb_stb_o && wb_cyc_o) begin
         if (slv_wait < 0) slv_wait = $urandom_range(0, 2);
         if (slv_wait == 0) begin
            slv_wait     = -1;
            wb_ack_i     = 1'b1;
            slv_real     = 1'b1;
            last_ack_cyc = cyc_cnt;
            if (!wb_we_o) begin
               if (wb_adr_o == 3'd4) begin
                  wb_dat_i = (slv_si < sr_script.size()) ? sr_script[slv_si] : sr_default;
                  slv_si++;
               end else if (wb_adr_o == 3'd3) begin
                  wb_dat_i = rxr_val;
               end else begin
                  wb_dat_i = 8'h00;
               end
               log_q.push_back(acc_t'({1'b0, wb_adr_o, 8'h00}));
            end else begin
               log_q.push_back(acc_t'({1'b1, wb_adr_o, wb_dat_o}));
            end
         end else begin
            slv_wait--;
         end
      end else if (spurious_en && ($urandom_range(0, 1) == 1)) begin
         wb_ack_i = 1'b1;
         wb_dat_i = 8'($urandom);
      end
   end

   // ---------------- reference model ----------------
   function automatic logic [7:0] sr_at(input int i);
      return (i < sr_script.size()) ? sr_script[i] : sr_default;
   endfunction

   function automatic acc_t mk(input logic we, input logic [2:0] adr, input logic [7:0] dat);
      return acc_t'({we, adr, dat});
   endfunction

   // Reads SR until the watched bit is clear, or POLL_MAX reads went by
   task automatic model_poll(inout int si, input int bit_i, output logic [7:0] sr, output bit tmo);
      int n = 0;
      tmo = 1'b0;
      forever begin
         sr = sr_at(si);
         si++;
         n++;
         exp_q.push_back(mk(1'b0, 3'd4, 8'h00));
         if (!sr[bit_i]) break;
         if (n == POLL_MAX) begin
            tmo = 1'b1;
            break;
         end
      end
   endtask

   task automatic model_cmd(input logic rw, input logic [6:0] a, input logic [7:0] d);
      int         si = 0;
      logic [7:0] sr;
      bit         tmo;
      exp_q.delete();
      exp_err  = 3'd0;
      exp_data = 8'h00;
      exp_q.push_back(mk(1'b1, 3'd3, {a, rw}));
      exp_q.push_back(mk(1'b1, 3'd4, 8'h90));
      model_poll(si, 1, sr, tmo);
      if (tmo) begin exp_err = 3'd4; return; end
      if (sr[5]) begin exp_err = 3'd3; return; end
      if (sr[7]) begin
         exp_err = 3'd1;
         exp_q.push_back(mk(1'b1, 3'd4, 8'h40));
         model_poll(si, 6, sr, tmo);
         if (tmo) exp_err = 3'd4;
         return;
      end
      if (!rw) begin
         exp_q.push_back(mk(1'b1, 3'd3, d));
         exp_q.push_back(mk(1'b1, 3'd4, 8'h50));
      end else begin
         exp_q.push_back(mk(1'b1, 3'd4, 8'h68));
      end
      model_poll(si, 1, sr, tmo);
      if (tmo) begin exp_err = 3'd4; return; end
      if (sr[5]) begin exp_err = 3'd3; return; end
      if (!rw) begin
         if (sr[7]) exp_err = 3'd2;
      end else begin
         exp_q.push_back(mk(1'b0, 3'd3, 8'h00));
         exp_data = rxr_val;
      end
   endtask

   // ---------------- command driver ----------------
   task automatic run_cmd(input string nm, input logic rw, input logic [6:0] a,
                          input logic [7:0] d, input int hold, input bit spur);
      int         n;
      logic [7:0] keep_data;
      logic [2:0] keep_err;
      model_cmd(rw, a, d);
      log_q.delete();
      slv_si = 0;
      n = 0;
      while (cmd_ready !== 1'b1 && n < 200) begin @(negedge wb_clk_i); n++; end
      cmd_valid = 1'b1;
      cmd_rw    = rw;
      cmd_addr  = a;
      cmd_data  = d;
      @(negedge wb_clk_i);
      cmd_valid = 1'b0;
      checks++;
      if (wb_stb_o !== 1'b1 || wb_adr_o !== 3'd3 || wb_dat_o !== {a, rw}) begin
         errors++;
         $display("FAIL %s txr_launch: stb=%b adr=%0d dat=%h, required stb=1 adr=3 dat=%h",
                  nm, wb_stb_o, wb_adr_o, wb_dat_o, {a, rw});
      end
      n = 0;
      while (rsp_valid !== 1'b1 && n < 2000) begin @(negedge wb_clk_i); n++; end
      checks++;
      if (rsp_valid !== 1'b1) begin
         errors++;
         $display("FAIL %s rsp_timeout: rsp_valid=%b, required 1", nm, rsp_valid);
         return;
      end
      checks++;
      if (cyc_cnt != last_ack_cyc + 1) begin
         errors++;
         $display("FAIL %s rsp_latency: rsp_valid at cycle %0d, required %0d", nm, cyc_cnt, last_ack_cyc + 1);
      end
      checks++;
      if (rsp_err !== exp_err || rsp_data !== exp_data || busy !== 1'b1) begin
         errors++;
         $display("FAIL %s rsp: err=%0d data=%h busy=%b, required err=%0d data=%h busy=1",
                  nm, rsp_err, rsp_data, busy, exp_err, exp_data);
      end
      keep_data   = rsp_data;
      keep_err    = rsp_err;
      spurious_en = spur;
      for (int i = 0; i < hold; i++) begin
         @(negedge wb_clk_i);
         checks++;
         if (rsp_valid !== 1'b1 || rsp_data !== keep_data || rsp_err !== keep_err || wb_stb_o !== 1'b0) begin
            errors++;
            $display("FAIL %s rsp_hold: valid=%b data=%h err=%0d stb=%b, required 1/%h/%0d/0",
                     nm, rsp_valid, rsp_data, rsp_err, wb_stb_o, keep_data, keep_err);
         end
      end
      spurious_en = 1'b0;
      rsp_ready   = 1'b1;
      @(negedge wb_clk_i);
      rsp_ready = 1'b0;
      checks++;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s rsp_consume: rsp_valid=%b cmd_ready=%b, required 0/1", nm, rsp_valid, cmd_ready);
      end
      checks++;
      if (log_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL %s access_count: got %0d, required %0d", nm, log_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
         checks++;
         if (log_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL %s access[%0d]: got we=%b adr=%0d dat=%h, required we=%b adr=%0d dat=%h",
                     nm, i, log_q[i].we, log_q[i].adr, log_q[i].dat, exp_q[i].we, exp_q[i].adr, exp_q[i].dat);
         end
      end
   endtask

   task automatic wait_ready(input string nm);
      int n = 0;
      while (cmd_ready !== 1'b1 && n < 200) begin @(negedge wb_clk_i); n++; end
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s ready_timeout: cmd_ready=%b, required 1", nm, cmd_ready);
      end
   endtask

   task automatic check_init_log(input string nm);
      acc_t init_exp[3];
      init_exp[0] = mk(1'b1, 3'd0, PRESCALE[7:0]);
      init_exp[1] = mk(1'b1, 3'd1, PRESCALE[15:8]);
      init_exp[2] = mk(1'b1, 3'd2, 8'h80);
      checks++;
      if (log_q.size() != 3) begin
         errors++;
         $display("FAIL %s init_count: got %0d, required 3", nm, log_q.size());
      end
      for (int i = 0; i < 3 && i < log_q.size(); i++) begin
         checks++;
         if (log_q[i] !== init_exp[i]) begin
            errors++;
            $display("FAIL %s init[%0d]: got adr=%0d dat=%h we=%b, required adr=%0d dat=%h we=1",
                     nm, i, log_q[i].adr, log_q[i].dat, log_q[i].we, init_exp[i].adr, init_exp[i].dat);
         end
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset;
      arst_i = 1'b0;
      repeat (3) @(negedge wb_clk_i);
      checks++;
      if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b0 ||
          rsp_data !== 8'h00 || rsp_err !== 3'd0) begin
         errors++;
         $display("FAIL reset_values: cyc=%b stb=%b rsp_valid=%b cmd_ready=%b data=%h err=%0d, required all 0",
                  wb_cyc_o, wb_stb_o, rsp_valid, cmd_ready, rsp_data, rsp_err);
      end
      log_q.delete();
      arst_i = 1'b1;
      @(negedge wb_clk_i);
      checks++;
      if (wb_stb_o !== 1'b1 || wb_adr_o !== 3'd0 || wb_we_o !== 1'b1 || wb_dat_o !== PRESCALE[7:0]) begin
         errors++;
         $display("FAIL reset_first_access: stb=%b adr=%0d we=%b dat=%h, required 1/0/1/%h",
                  wb_stb_o, wb_adr_o, wb_we_o, wb_dat_o, PRESCALE[7:0]);
      end
      wait_ready("reset");
      check_init_log("reset");
   endtask

   task automatic test_write_ack;
      sr_script = '{8'h02, 8'h00, 8'h02, 8'h02, 8'h00};
      sr_default = 8'h00;
      run_cmd("write_ack", 1'b0, 7'h50, 8'hA5, 0, 1'b0);
   endtask

   task automatic test_read;
      sr_script = '{8'h02, 8'h00, 8'h00};
      sr_default = 8'h00;
      rxr_val = 8'h3C;
      run_cmd("read", 1'b1, 7'h50, 8'h00, 1, 1'b0);
   endtask

   task automatic test_addr_nack;
      sr_script = '{8'h02, 8'h80, 8'h40, 8'h40, 8'h00};
      sr_default = 8'h00;
      run_cmd("addr_nack", 1'b0, 7'h22, 8'h5A, 0, 1'b0);
   endtask

   task automatic test_poll_timeout;
      sr_script.delete();
      sr_default = 8'h02;
      run_cmd("poll_timeout", 1'b0, 7'h11, 8'h77, 5, 1'b1);
      sr_default = 8'h00;
   endtask

   task automatic test_back_to_back;
      logic [7:0] sr;
      for (int k = 0; k < 10; k++) begin
         sr_script.delete();
         for (int j = 0; j < 14; j++) begin
            sr = 8'($urandom) & 8'h1D;
            if ($urandom_range(0, 1) == 1) sr[1] = 1'b1;
            if ($urandom_range(0, 7) == 0) sr[5] = 1'b1;
            if ($urandom_range(0, 3) == 0) sr[7] = 1'b1;
            if ($urandom_range(0, 2) == 0) sr[6] = 1'b1;
            sr_script.push_back(sr);
         end
         sr_default = 8'h00;
         rxr_val    = 8'($urandom);
         run_cmd("random", 1'($urandom), 7'($urandom), 8'($urandom), $urandom_range(0, 3), 1'b0);
      end
   endtask

   task automatic test_reset_mid_access;
      int n = 0;
      bit found = 1'b0;
      sr_script.delete();
      sr_default = 8'h02;
      wait_ready("mid_reset");
      cmd_valid = 1'b1;
      cmd_rw    = 1'b0;
      cmd_addr  = 7'h33;
      cmd_data  = 8'hC3;
      @(negedge wb_clk_i);
      cmd_valid = 1'b0;
      while (n < 200) begin
         @(posedge wb_clk_i);
         #1;
         if (wb_stb_o === 1'b1 && wb_adr_o === 3'd4 && wb_we_o === 1'b0) begin
            found = 1'b1;
            break;
         end
         n++;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL mid_reset poll_seen: no SR read within 200 cycles, required one");
      end
      arst_i = 1'b0;
      #1;
      checks++;
      if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset bus_drop: cyc=%b stb=%b, required 0/0", wb_cyc_o, wb_stb_o);
      end
      sr_default = 8'h00;
      repeat (3) @(negedge wb_clk_i);
      log_q.delete();
      checks++;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset hold: rsp_valid=%b cmd_ready=%b, required 0/0", rsp_valid, cmd_ready);
      end
      arst_i = 1'b1;
      wait_ready("mid_reset");
      check_init_log("mid_reset");
      sr_script = '{8'h00, 8'h00};
      rxr_val = 8'h96;
      run_cmd("after_reset", 1'b1, 7'h50, 8'h00, 0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_write_ack();
      test_read();
      test_addr_nack();
      test_poll_timeout();
      test_back_to_back();
      test_reset_mid_access();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
